ysyx_22041461_div_unit: RTL

YSYX_22041461_DIV_UNIT -- requirements
Module: ysyx_22041461_div_unit

---
 rtl/ysyx_22041461_div_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_22041461_div_unit.sv
// Iterative restoring divider/remainder unit (DIV/DIVU/REM/REMU plus W variants).
// Optional macro YSYX_22041461_DIV_FAST_EN: divide-by-zero and signed overflow skip the iterations.
module ysyx_22041461_div_unit #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [1:0]      op,
  input  logic            word,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, result_q, result_d;
  logic [1:0]        op_q, op_d;
  logic              word_q, word_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic              accept, word_eff, sgn, neg1, neg2, dz, ge;
  logic [XLEN-1:0]   ea1, ea2, mag1, mag2, step_rem, qv, rv, sel, result_fin;
  logic [XLEN:0]     sh;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

  // Operand conditioning at acceptance: effective width, sign handling, magnitudes
  assign accept   = in_valid && in_ready_q && !flush;
  assign word_eff = (XLEN == 64) && word;
  assign sgn      = !op[0];
  assign ea1 = word_eff ? (sgn ? XLEN'(signed'(src1[31:0])) : XLEN'(src1[31:0])) : src1;
  assign ea2 = word_eff ? (sgn ? XLEN'(signed'(src2[31:0])) : XLEN'(src2[31:0])) : src2;
  assign neg1 = sgn && ea1[XLEN-1];
  assign neg2 = sgn && ea2[XLEN-1];
  assign mag1 = neg1 ? -ea1 : ea1;
  assign mag2 = neg2 ? -ea2 : ea2;
  assign dz   = (ea2 == '0);

`ifdef YSYX_22041461_DIV_FAST_EN
  logic            ovf;
  logic [XLEN-1:0] min_neg;
  assign min_neg = word_eff ? XLEN'(signed'(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
  assign ovf     = sgn && (ea1 == min_neg) && (ea2 == '1);
`endif

  // One restoring step: shift in next dividend bit, trial-subtract the divisor
  assign sh       = {rem_q, quo_q[XLEN-1]};
  assign ge       = (sh >= {1'b0, dvs_q});
  assign step_rem = ge ? XLEN'(sh - {1'b0, dvs_q}) : sh[XLEN-1:0];

  // Sign fix-up of the unsigned quotient/remainder; a zero divisor forces all-ones quotient
  assign qv         = dz_q ? '1 : (qneg_q ? -quo_q : quo_q);
  assign rv         = rneg_q ? -rem_q : rem_q;
  assign sel        = op_q[1] ? rv : qv;
  assign result_fin = word_q ? XLEN'(signed'(sel[31:0])) : sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (flush) state_d = IDLE;
               else if (cnt_q == '0) state_d = DONE;
      DONE:    if (flush || out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    op_d     = op_q;
    word_d   = word_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    result_d = result_q;
    unique case (state_d)
      IDLE:    in_ready_d  = 1'b1;
      DONE:    out_valid_d = 1'b1;
      default: ;
    endcase
    if (accept) begin
      cnt_d  = CNT_W'(word_eff ? 32 : XLEN);
      rem_d  = '0;
      quo_d  = word_eff ? (mag1 << 32) : mag1;
      dvs_d  = mag2;
      op_d   = op;
      word_d = word_eff;
      qneg_d = neg1 ^ neg2;
      rneg_d = neg1;
      dz_d   = dz;
`ifdef YSYX_22041461_DIV_FAST_EN
      if (dz || ovf) begin
        cnt_d = '0;
        quo_d = mag1;
        rem_d = dz ? mag1 : '0;
      end
`endif
    end else if (state_q == CALC && !flush) begin
      if (cnt_q != '0) begin
        rem_d = step_rem;
        quo_d = {quo_q[XLEN-2:0], ge};
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        result_d = result_fin;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      op_q        <= '0;
      word_q      <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dz_q        <= 1'b0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      op_q        <= op_d;
      word_q      <= word_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      dz_q        <= dz_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
